// File: rtl/btn_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// btn_pulse_conditioner
//
// Front end for the stopwatch push buttons. Each raw, bouncing, active-low
// button input is synchronised to Clk by two flops, debounced by a four-state
// FSM (REL, PCHK, HELD, RCHK), and turned into a one-clock active-low press
// pulse plus a debounced level.
//
// Parameters:
//   N_BTN            number of independent button channels
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a change (>= 2)
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//   REPEAT_CYCLES    auto-repeat period while held (BTN_AUTO_REPEAT_EN only)
//
// Ports:
//   Clk          in   system clock, rising edge
//   Rst          in   synchronous reset, active low
//   btn_raw_n    in   raw asynchronous button levels, 0 = pressed
//   btn_pulse_n  out  registered one-clock active-low pulse per accepted press
//   btn_level_n  out  registered debounced level, 0 = held
//
// Build option:
//   BTN_AUTO_REPEAT_EN  when defined, a held button also pulses every
//                       REPEAT_CYCLES clocks after its initial press pulse.
// -----------------------------------------------------------------------------
module btn_pulse_conditioner #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
`ifdef BTN_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES   = 25000000
`endif
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [N_BTN-1:0] btn_raw_n,
    output logic [N_BTN-1:0] btn_pulse_n,
    output logic [N_BTN-1:0] btn_level_n
);

    localparam logic [1:0] ST_REL  = 2'd0;
    localparam logic [1:0] ST_PCHK = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;
    localparam logic [1:0] ST_RCHK = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTO_REPEAT_EN
    localparam int               RPT_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt [N_BTN];
`endif

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync_n;
    logic [1:0]       warm;
    logic [N_BTN-1:0] armed;
    logic [1:0]       state [N_BTN];
    logic [CNT_W-1:0] cnt   [N_BTN];

    // The synchroniser reloads with 1 (released) on reset, so its output does
    // not reflect the pins until two clocks later. warm tracks that refill.
    // A channel is armed only once a genuine released sample is seen in REL;
    // a button held through reset therefore debounces to HELD silently and
    // must be released before its next press may pulse.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            sync1       <= '1;
            sync_n      <= '1;
            warm        <= '0;
            armed       <= '0;
            btn_level_n <= '1;
            btn_pulse_n <= '1;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                state[i] <= ST_REL;
                cnt[i]   <= '0;
`ifdef BTN_AUTO_REPEAT_EN
                rpt_cnt[i] <= '0;
`endif
            end
        end else begin
            sync1       <= btn_raw_n;
            sync_n      <= sync1;
            warm        <= {warm[0], 1'b1};
            btn_pulse_n <= '1;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                case (state[i])
                    ST_REL: begin
                        if (!sync_n[i]) begin
                            state[i] <= ST_PCHK;
                            cnt[i]   <= CNT_W'(1);
                        end else if (warm[1]) begin
                            armed[i] <= 1'b1;
                        end
                    end
                    ST_PCHK: begin
                        if (sync_n[i]) begin
                            state[i] <= ST_REL;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]       <= ST_HELD;
                            cnt[i]         <= '0;
                            btn_level_n[i] <= 1'b0;
                            if (armed[i]) btn_pulse_n[i] <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
                            rpt_cnt[i] <= '0;
`endif
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    ST_HELD: begin
                        if (sync_n[i]) begin
                            state[i] <= ST_RCHK;
                            cnt[i]   <= CNT_W'(1);
`ifdef BTN_AUTO_REPEAT_EN
                            rpt_cnt[i] <= '0;
                        end else if (rpt_cnt[i] == RPT_LAST) begin
                            rpt_cnt[i] <= '0;
                            if (armed[i]) btn_pulse_n[i] <= 1'b0;
                        end else begin
                            rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
`endif
                        end
                    end
                    ST_RCHK: begin
                        if (!sync_n[i]) begin
                            state[i] <= ST_HELD;
                            cnt[i]   <= '0;
`ifdef BTN_AUTO_REPEAT_EN
                            rpt_cnt[i] <= '0;
`endif
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]       <= ST_REL;
                            cnt[i]         <= '0;
                            btn_level_n[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state[i] <= ST_REL;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/btn_pulse_conditioner.md
Name: btn_pulse_conditioner

Overview:
- Upstream stage of the stopwatch.
- Takes raw, bouncing, active-low push-button inputs (start, stop, spare) from the board pins.
- For each button: synchronises to the system clock, debounces, and emits a clean one-clock active-low pulse per press.
- The pulse drives the stopwatch fStart/fStop inputs directly; also provides debounced level outputs for LEDs and diagnostics.

Parameters:
- N_BTN, 2, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a level change (20 ms at 50 MHz). Must be >= 2.
- CNT_W, 20, counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- REPEAT_CYCLES, 25000000, auto-repeat period while held. Used only with the optional feature.

Ports:
- Clk  input  1  system clock, rising edge; 50 MHz nominal.
- Rst  input  1  synchronous, active-low reset.
- btn_raw_n  input  N_BTN  raw asynchronous button levels; 0 = pressed.
- btn_pulse_n  output  N_BTN  registered one-clock active-low press pulse per channel.
- btn_level_n  output  N_BTN  registered debounced level; 0 = held.

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-low, and sampled only on the Clk rising edge.
- Reset values:
  - Both synchroniser flops = 1.
  - Counters = 0.
  - FSM = REL.
  - btn_level_n = all 1.
  - btn_pulse_n = all 1.
- Reset mid-count or while held: all state is discarded. A button still held after reset release must first pass through a full release before it can pulse. No pulse is generated for a press already in progress at reset.
- Synchroniser: 2-flop per channel, giving sync_n.
- Per-channel FSM, all registered:
  - REL: stable released; btn_level_n = 1.
    - sync_n = 0 -> go to PCHK, cnt = 1.
  - PCHK: counting a candidate press.
    - sync_n = 1 -> back to REL, cnt = 0 (bounce rejected).
    - sync_n = 0 and cnt = DEBOUNCE_CYCLES-1 -> go to HELD. On that same edge: btn_level_n <= 0 and btn_pulse_n <= 0 for exactly one clock.
    - Otherwise cnt++.
  - HELD: stable pressed; btn_level_n = 0; btn_pulse_n = 1.
    - sync_n = 1 -> go to RCHK, cnt = 1.
  - RCHK: counting a candidate release.
    - sync_n = 0 -> back to HELD, cnt = 0.
    - sync_n = 1 and cnt = DEBOUNCE_CYCLES-1 -> go to REL with btn_level_n <= 1. No pulse on release.
    - Otherwise cnt++.
- Latency: a clean press first sampled at edge k produces btn_pulse_n = 0 during the cycle after edge k+1+DEBOUNCE_CYCLES. The same latency applies to release on btn_level_n.
- Pulse width: always exactly one Clk period, regardless of hold length. Releasing and pressing again requires a full RCHK/REL/PCHK sequence.
- Channels are fully independent. Simultaneous presses on several channels pulse on the same cycle; there is no priority and no masking.
- Counter never wraps. It is bounded by DEBOUNCE_CYCLES-1 and cleared on every state change.
- A glitch shorter than DEBOUNCE_CYCLES on any state produces no output change.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined:
  - Each channel has an additional repeat counter, cleared on entry to HELD.
  - While in HELD, every REPEAT_CYCLES clocks, btn_pulse_n is driven 0 for one clock.
  - The first repeat pulse occurs REPEAT_CYCLES clocks after the initial press pulse.
  - Leaving HELD (entering RCHK) clears and freezes the repeat counter. A return RCHK->HELD restarts it from 0.
- Undefined: no repeat counter logic; exactly one pulse per accepted press.

Test Plan (sim parameters DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10, N_BTN=2, 20 ns clock):
- Reset: hold Rst=0 for 3 clocks with btn_raw_n=2'b00 -> all outputs 1. After Rst=1, still no pulse, because the FSM sits in PCHK/HELD without issuing a pulse until the buttons are released and pressed again.
- Clean press: ch0 raw 1->0 and held -> exactly one 20 ns low pulse on btn_pulse_n[0], 5 edges after first low sample; btn_level_n[0]=0 from the same edge. Release -> btn_level_n[0]=1 after 5 edges; no pulse.
- Bounce rejection: ch1 raw toggles 0,1,0,1 each for 2 clocks, then stays 1 -> no pulse and btn_level_n[1] stays 1. Then bounce 0/1 for 3 clocks, then stable 0 -> exactly one pulse.
- Simultaneous: both raw fall on the same edge -> btn_pulse_n=2'b00 on one identical cycle.
- Reset mid-operation: ch0 in PCHK with cnt=2, assert Rst for 1 clock -> no pulse, state REL. Holding raw low afterwards yields no pulse until release then re-press.
- BTN_AUTO_REPEAT_EN defined, ch0 held 40 clocks -> initial pulse, then pulses at +10, +20, +30 clocks; none after release. Macro undefined -> single pulse only.
